// File: rtl/interrupt_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller_pkg
// Description : Register map, control-bit positions and state encoding shared
//               by the interrupt controller and its priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package interrupt_controller_pkg;

    // Register select values on ADDR_INT
    localparam logic [1:0] INT_REG_PEND = 2'd0;
    localparam logic [1:0] INT_REG_ENAB = 2'd1;
    localparam logic [1:0] INT_REG_EDGE = 2'd2;
    localparam logic [1:0] INT_REG_CTRL = 2'd3;

    // CTRL register bit positions
    localparam int CTRL_GIE_BIT   = 15;
    localparam int CTRL_EOI_BIT   = 14;
    localparam int CTRL_INSVC_BIT = 14;
    localparam int CTRL_VALID_BIT = 4;

    // Service state: IDLE offers interrupts, SERVICE blocks until EOI
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } int_state_t;

endpackage : interrupt_controller_pkg
`default_nettype wire

// File: rtl/interrupt_controller_int_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : int_priority_encoder
// Description : Combinational fixed-priority encoder; index 0 wins.
// Revision    : 1.0 - initial release
// ============================================================================
module int_priority_encoder #(
    parameter int N_IRQ = 8
) (
    input  logic [N_IRQ-1:0] req,
    output logic [3:0]       index,
    output logic             valid
);

    // Scan from the top so the lowest set index is the last one written
    always_comb begin
        index = 4'd0;
        valid = 1'b0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule : int_priority_encoder
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller
// Description : Latches, masks and prioritises N_IRQ interrupt lines, raises
//               INT_REQ with the winning vector and runs the ack / EOI
//               handshake with the CPU. Four 16-bit bus registers.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int N_IRQ       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WR_INT,
    input  logic             RD_INT,
    input  logic [1:0]       ADDR_INT,
    input  logic [15:0]      DATA_IN,
    output logic [15:0]      DOUT,
    input  logic [N_IRQ-1:0] IRQ,
    output logic             INT_REQ,
    input  logic             INT_ACK,
    output logic [3:0]       INT_VECTOR
);

    logic [N_IRQ-1:0] r_sync [SYNC_STAGES];
    logic [N_IRQ-1:0] r_prev;
    logic [N_IRQ-1:0] r_pend;
    logic [N_IRQ-1:0] r_enab;
    logic [N_IRQ-1:0] r_edge_en;
    logic             r_gie;
    logic             r_int_req;
    logic [3:0]       r_vec;
    int_state_t       r_state;
    int_state_t       w_state_nxt;

    logic [N_IRQ-1:0] w_synced;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_data;
    logic [N_IRQ-1:0] w_w1c;
    logic [N_IRQ-1:0] w_ack_clr;
    logic [N_IRQ-1:0] w_pend_nxt;
    logic [3:0]       w_best;
    logic             w_valid;
    logic             w_insvc;
    logic             w_ack_take;
    logic             w_eoi;
    logic             w_int_req_nxt;
    logic [3:0]       w_vec_nxt;
    logic [15:0]      w_pend16;
    logic [15:0]      w_enab16;
    logic [15:0]      w_edge16;
    logic             w_unused;

    assign w_synced   = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_synced & ~r_prev;
    assign w_data     = DATA_IN[N_IRQ-1:0];
    assign w_insvc    = (r_state == ST_SERVICE);
    assign w_w1c      = (WR_INT && ADDR_INT == INT_REG_PEND) ? w_data : '0;
    assign w_eoi      = WR_INT && (ADDR_INT == INT_REG_CTRL) && DATA_IN[CTRL_EOI_BIT];
    // An ack only counts when a request was actually being offered
    assign w_ack_take = INT_ACK && r_int_req && !w_insvc;
    assign w_unused   = ^{RD_INT, DATA_IN};

    int_priority_encoder #(
        .N_IRQ (N_IRQ)
    ) u_prio (
        .req   (r_pend & r_enab),
        .index (w_best),
        .valid (w_valid)
    );

    // Synchroniser chain and edge-detector history, independent of EDGE mode
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= IRQ;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_synced;
        end
    end

    // Pending next-state: edge bits latch (new edge beats clears), level bits mirror the line
    always_comb begin
        w_ack_clr = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            w_ack_clr[i] = w_ack_take && (w_best == 4'(i));
        end
        w_pend_nxt = (r_edge_en & ((r_pend & ~w_w1c & ~w_ack_clr) | w_rise))
                   | (~r_edge_en & w_synced);
    end

    // Configuration and pending registers
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_pend    <= '0;
            r_enab    <= '0;
            r_edge_en <= '0;
            r_gie     <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            if (WR_INT && ADDR_INT == INT_REG_ENAB) r_enab    <= w_data;
            if (WR_INT && ADDR_INT == INT_REG_EDGE) r_edge_en <= w_data;
            if (WR_INT && ADDR_INT == INT_REG_CTRL) r_gie     <= DATA_IN[CTRL_GIE_BIT];
        end
    end

    // Service FSM state register plus registered CPU-facing outputs
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state   <= ST_IDLE;
            r_int_req <= 1'b0;
            r_vec     <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_int_req <= w_int_req_nxt;
            r_vec     <= w_vec_nxt;
        end
    end

    // Service FSM next-state; vector tracks BEST only while idle
    always_comb begin
        w_state_nxt   = r_state;
        w_vec_nxt     = r_vec;
        w_int_req_nxt = r_gie && w_valid && !w_insvc && !INT_ACK;
        case (r_state)
            ST_IDLE: begin
                w_vec_nxt = w_best;
                if (w_ack_take) w_state_nxt = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (w_eoi) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Combinational read mux; bits above N_IRQ read as zero
    always_comb begin
        w_pend16 = '0;
        w_enab16 = '0;
        w_edge16 = '0;
        w_pend16[N_IRQ-1:0] = r_pend;
        w_enab16[N_IRQ-1:0] = r_enab;
        w_edge16[N_IRQ-1:0] = r_edge_en;
        DOUT = '0;
        case (ADDR_INT)
            INT_REG_PEND: DOUT = w_pend16;
            INT_REG_ENAB: DOUT = w_enab16;
            INT_REG_EDGE: DOUT = w_edge16;
            default: begin
                DOUT[CTRL_GIE_BIT]   = r_gie;
                DOUT[CTRL_INSVC_BIT] = w_insvc;
                DOUT[CTRL_VALID_BIT] = w_valid;
                DOUT[3:0]            = w_best;
            end
        endcase
    end

    assign INT_REQ    = r_int_req;
    assign INT_VECTOR = r_vec;

endmodule : interrupt_controller
`default_nettype wire
